// File: rtl/alu_uart_sequencer.sv
// Frame controller: gathers opcode/A/B bytes from the UART RX, drives the ALU, sends the result via UART TX.
// Optional inter-byte frame timeout compiled in with `define RX_TIMEOUT_EN.
module alu_uart_sequencer #(
  parameter int unsigned NB_DATA      = 8,
  parameter int unsigned NB_OP        = 6,
  parameter int unsigned TIMEOUT_CLKS = 104160
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_A  = 3'd1,
    WAIT_B  = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 2");
  end

  state_t             state_q, state_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               op_ok_c;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Opcode byte is legal only for the eight supported ops with the upper bits clear.
  always_comb begin
    op_ok_c = 1'b0;
    if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
      case (i_rx_data[NB_OP-1:0])
        NB_OP'(6'h20), NB_OP'(6'h22), NB_OP'(6'h24), NB_OP'(6'h25),
        NB_OP'(6'h26), NB_OP'(6'h03), NB_OP'(6'h02), NB_OP'(6'h27): op_ok_c = 1'b1;
        default: op_ok_c = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
`ifdef RX_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          if (op_ok_c) begin
            op_d    = i_rx_data[NB_OP-1:0];
            state_d = WAIT_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_A: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef RX_TIMEOUT_EN
    // A byte arriving on the expiry edge wins over the timeout.
    if (i_rx_done) begin
      cnt_d = '0;
    end else if (state_q == WAIT_A || state_q == WAIT_B) begin
      if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
    busy_d = (state_d == EXEC) || (state_d == WAIT_TX);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef RX_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef RX_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign o_alu_op   = op_q;
  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule
